// File: rtl/disp_tgen_multi.sv
// -----------------------------------------------------------------------------
// disp_tgen_multi
//
// Display-timing generator for the disparity output path. It drains a
// first-word-fall-through FIFO and produces HS/VS/DE together with LANES
// pixels per clock. Geometry is held in an active set that is only replaced
// from a pending (shadow) set at safe points: immediately while stopped, or
// on the last cycle of a frame while running. FIFO underflow during DE emits
// FILL pixels and bumps a saturating error counter.
//
// Parameters
//   DW     bits per pixel
//   LANES  pixels per clock (1, 2 or 4)
//   CW     width of the timing counters and cfg fields
//   FILL   pixel value emitted when the FIFO is empty during DE
//
// Ports
//   rd_clk, rd_rstn      pixel clock, asynchronous active-low reset
//   enable               run request; a drop while running finishes the frame
//   cfg_h_* / cfg_v_*    sync/back/active/total, in clocks / lines
//   cfg_update           one-cycle pulse, captures cfg_* into the pending set
//   fifo_empty/fifo_data FWFT FIFO status and head word (lane 0 in LSBs)
//   fifo_rd_en           FIFO pop, combinational
//   out_data/out_hs/out_vs/out_de  registered pixel stream, 1 cycle behind
//                        the counters
//   frame_start          pulse aligned with the first pixel slot of a frame
//   underflow            pulse for a DE beat that found the FIFO empty
//   err_cnt              saturating underflow count, cleared on apply
//   cfg_busy             pending set captured but not yet applied
// -----------------------------------------------------------------------------
module disp_tgen_multi #(
    parameter int unsigned   DW    = 8,
    parameter int unsigned   LANES = 1,
    parameter int unsigned   CW    = 12,
    parameter logic [DW-1:0] FILL  = '0
) (
    input  logic                rd_clk,
    input  logic                rd_rstn,
    input  logic                enable,
    input  logic [CW-1:0]       cfg_h_sync,
    input  logic [CW-1:0]       cfg_h_back,
    input  logic [CW-1:0]       cfg_h_active,
    input  logic [CW-1:0]       cfg_h_total,
    input  logic [CW-1:0]       cfg_v_sync,
    input  logic [CW-1:0]       cfg_v_back,
    input  logic [CW-1:0]       cfg_v_active,
    input  logic [CW-1:0]       cfg_v_total,
    input  logic                cfg_update,
    input  logic                fifo_empty,
    input  logic [DW*LANES-1:0] fifo_data,
    output logic                fifo_rd_en,
    output logic [DW*LANES-1:0] out_data,
    output logic                out_hs,
    output logic                out_vs,
    output logic                out_de,
    output logic                frame_start,
    output logic                underflow,
    output logic [15:0]         err_cnt,
    output logic                cfg_busy
);

    localparam int unsigned PW = DW * LANES;

    typedef struct packed {
        logic [CW-1:0] sync;
        logic [CW-1:0] back;
        logic [CW-1:0] active;
        logic [CW-1:0] total;
    } tim_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // 1080p60 timing out of reset
    localparam tim_t H_DEF = {CW'(44), CW'(148), CW'(1920), CW'(2200)};
    localparam tim_t V_DEF = {CW'(5),  CW'(36),  CW'(1080), CW'(1125)};

    // Make a geometry safe to count with: total of at least 2 so that
    // total-1 never underflows, and an active window that fits inside the
    // line/frame after sync and back porch. Sums use one extra bit.
    function automatic tim_t clamp_tim(input tim_t t);
        tim_t         r;
        logic [CW:0]  sb;
        logic [CW:0]  room;
        r = t;
        if (t.total < CW'(2)) begin
            r.total = CW'(2);
        end
        sb   = {1'b0, t.sync} + {1'b0, t.back};
        room = '0;
        if (sb >= {1'b0, r.total}) begin
            r.active = '0;
        end else begin
            room = {1'b0, r.total} - sb;
            if ({1'b0, t.active} > room) begin
                r.active = room[CW-1:0];
            end
        end
        return r;
    endfunction

    state_t            state_q, state_d;
    tim_t              h_act_q, v_act_q;
    tim_t              h_pend_q, v_pend_q;
    tim_t              h_cfg_in, v_cfg_in;
    logic              cfg_busy_q;
    logic [CW-1:0]     h_cnt_q, h_cnt_d;
    logic [CW-1:0]     v_cnt_q, v_cnt_d;
    logic [15:0]       err_cnt_q, err_cnt_d;

    logic              out_hs_q, out_vs_q, out_de_q;
    logic              frame_start_q, underflow_q;
    logic [PW-1:0]     out_data_q, out_data_d;
    logic [PW-1:0]     fill_word;

    logic              run_c, h_last_c, v_last_c, eof_c, apply_c;
    logic              hs_c, vs_c, de_c, uf_c;
    logic [CW:0]       h_de_lo, h_de_hi, v_de_lo, v_de_hi;

    assign h_cfg_in = {cfg_h_sync, cfg_h_back, cfg_h_active, cfg_h_total};
    assign v_cfg_in = {cfg_v_sync, cfg_v_back, cfg_v_active, cfg_v_total};

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_fill
            assign fill_word[gi*DW +: DW] = FILL;
        end
    endgenerate

    // ---------------------------------------------------------------- decode
    assign run_c    = (state_q == ST_RUN);
    assign h_last_c = (h_cnt_q == h_act_q.total - CW'(1));
    assign v_last_c = (v_cnt_q == v_act_q.total - CW'(1));
    assign eof_c    = run_c & h_last_c & v_last_c;

    // An update in the same cycle as an apply point wins: the freshly
    // captured values wait for the following apply point.
    assign apply_c  = cfg_busy_q & ~cfg_update & (~run_c | eof_c);

    assign h_de_lo  = {1'b0, h_act_q.sync} + {1'b0, h_act_q.back};
    assign h_de_hi  = h_de_lo + {1'b0, h_act_q.active};
    assign v_de_lo  = {1'b0, v_act_q.sync} + {1'b0, v_act_q.back};
    assign v_de_hi  = v_de_lo + {1'b0, v_act_q.active};

    assign hs_c     = run_c & (h_cnt_q < h_act_q.sync);
    assign vs_c     = run_c & (v_cnt_q < v_act_q.sync);
    assign de_c     = run_c
                    & ({1'b0, h_cnt_q} >= h_de_lo) & ({1'b0, h_cnt_q} < h_de_hi)
                    & ({1'b0, v_cnt_q} >= v_de_lo) & ({1'b0, v_cnt_q} < v_de_hi);
    assign uf_c     = de_c & fifo_empty;

    assign fifo_rd_en = de_c & ~fifo_empty;

    // ----------------------------------------------------- FSM and counters
    always_comb begin
        state_d = state_q;
        h_cnt_d = '0;
        v_cnt_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (!fifo_empty) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (h_last_c) begin
                    h_cnt_d = '0;
                    v_cnt_d = v_last_c ? '0 : v_cnt_q + CW'(1);
                end else begin
                    h_cnt_d = h_cnt_q + CW'(1);
                    v_cnt_d = v_cnt_q;
                end
                // A dropped enable only takes effect once the frame is complete
                if (eof_c && !enable) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (apply_c) begin
            err_cnt_d = '0;
        end else if (uf_c && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_comb begin
        out_data_d = '0;
        if (de_c) begin
            out_data_d = fifo_empty ? fill_word : fifo_data;
        end
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge rd_clk or negedge rd_rstn) begin
        if (!rd_rstn) begin
            state_q    <= ST_IDLE;
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            err_cnt_q  <= '0;
            h_act_q    <= H_DEF;
            v_act_q    <= V_DEF;
            h_pend_q   <= H_DEF;
            v_pend_q   <= V_DEF;
            cfg_busy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            err_cnt_q <= err_cnt_d;
            if (apply_c) begin
                h_act_q <= clamp_tim(h_pend_q);
                v_act_q <= clamp_tim(v_pend_q);
            end
            if (cfg_update) begin
                h_pend_q   <= h_cfg_in;
                v_pend_q   <= v_cfg_in;
                cfg_busy_q <= 1'b1;
            end else if (apply_c) begin
                cfg_busy_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge rd_clk or negedge rd_rstn) begin
        if (!rd_rstn) begin
            out_hs_q      <= 1'b0;
            out_vs_q      <= 1'b0;
            out_de_q      <= 1'b0;
            out_data_q    <= '0;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            out_hs_q      <= hs_c;
            out_vs_q      <= vs_c;
            out_de_q      <= de_c;
            out_data_q    <= out_data_d;
            frame_start_q <= run_c & (h_cnt_q == '0) & (v_cnt_q == '0);
            underflow_q   <= uf_c;
        end
    end

    assign out_hs      = out_hs_q;
    assign out_vs      = out_vs_q;
    assign out_de      = out_de_q;
    assign out_data    = out_data_q;
    assign frame_start = frame_start_q;
    assign underflow   = underflow_q;
    assign err_cnt     = err_cnt_q;
    assign cfg_busy    = cfg_busy_q;

endmodule

// File: tb/tb_disp_tgen_multi.sv
// -----------------------------------------------------------------------------
// Bench for disp_tgen_multi (LANES=4, DW=8, FILL=8'h5A).
// The reference model tracks a linear position within the frame and derives
// h/v from it with division, applies cfg with a plain-integer clamp, and
// predicts every registered output for the next edge. Inputs change just
// after the rising edge; the model and all checks run on the falling edge.
// -----------------------------------------------------------------------------
module tb_disp_tgen_multi;

    localparam int DW    = 8;
    localparam int LANES = 4;
    localparam int CW    = 12;
    localparam logic [7:0]  FILL   = 8'h5A;
    localparam logic [31:0] FILL_W = {4{FILL}};

    logic              rd_clk = 1'b0;
    logic              rd_rstn = 1'b0;
    logic              enable = 1'b0;
    logic [CW-1:0]     cfg_h_sync = '0, cfg_h_back = '0, cfg_h_active = '0, cfg_h_total = '0;
    logic [CW-1:0]     cfg_v_sync = '0, cfg_v_back = '0, cfg_v_active = '0, cfg_v_total = '0;
    logic              cfg_update = 1'b0;
    logic              fifo_empty = 1'b1;
    logic [31:0]       fifo_data;
    logic              fifo_rd_en;
    logic [31:0]       out_data;
    logic              out_hs, out_vs, out_de, frame_start, underflow, cfg_busy;
    logic [15:0]       err_cnt;

    always #5 rd_clk = ~rd_clk;

    disp_tgen_multi #(.DW(DW), .LANES(LANES), .CW(CW), .FILL(FILL)) dut (
        .rd_clk(rd_clk), .rd_rstn(rd_rstn), .enable(enable),
        .cfg_h_sync(cfg_h_sync), .cfg_h_back(cfg_h_back),
        .cfg_h_active(cfg_h_active), .cfg_h_total(cfg_h_total),
        .cfg_v_sync(cfg_v_sync), .cfg_v_back(cfg_v_back),
        .cfg_v_active(cfg_v_active), .cfg_v_total(cfg_v_total),
        .cfg_update(cfg_update), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd_en(fifo_rd_en), .out_data(out_data), .out_hs(out_hs),
        .out_vs(out_vs), .out_de(out_de), .frame_start(frame_start),
        .underflow(underflow), .err_cnt(err_cnt), .cfg_busy(cfg_busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk_word(input int n);
        logic [7:0] b0;
        b0 = 8'(4 * n);
        return {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0};
    endfunction

    // ------------------------------------------------------------ FIFO source
    bit pop_flag = 0;
    int fifo_word = 0;
    initial begin
        fifo_data = mk_word(0);
        forever begin
            @(posedge rd_clk);
            #1;
            if (pop_flag) begin
                fifo_word++;
                fifo_data = mk_word(fifo_word);
            end
        end
    end

    // ------------------------------------------------------------ model state
    int act_g [8];   // h sync/back/active/total, v sync/back/active/total
    int pend_g [8];
    int m_mode;      // 0 idle, 1 wait, 2 run
    int m_pos;       // cycle index inside the current frame
    bit m_busy;
    int m_err;
    int m_word = 0;  // next FIFO word the model expects to see popped
    bit e_hs, e_vs, e_de, e_uf, e_fs, e_busy;
    logic [31:0] e_data;
    int e_err;

    // monitor counters read by the directed sequence
    int cyc = 0, fs_cnt = 0, last_fs_cyc = 0, period_last = 0;
    int de_frame = 0, de_last_frame = 0, rd_frame = 0, rd_last_frame = 0;
    int de_run = 0, run_last = 0, de_total = 0, uf_cnt = 0;

    always @(negedge rd_clk) begin
        if (!rd_rstn) begin
            chk("rst_hs", out_hs, 0);
            chk("rst_vs", out_vs, 0);
            chk("rst_de", out_de, 0);
            chk("rst_data", out_data, 0);
            chk("rst_fs", frame_start, 0);
            chk("rst_uf", underflow, 0);
            chk("rst_err", err_cnt, 0);
            chk("rst_busy", cfg_busy, 0);
            chk("rst_rd_en", fifo_rd_en, 0);
            act_g  = '{44, 148, 1920, 2200, 5, 36, 1080, 1125};
            pend_g = act_g;
            m_mode = 0; m_pos = 0; m_busy = 0; m_err = 0;
            e_hs = 0; e_vs = 0; e_de = 0; e_uf = 0; e_fs = 0; e_busy = 0;
            e_data = '0; e_err = 0;
            pop_flag = 0;
            de_run = 0;
        end else begin : model_step
            int h, v, ht, vt;
            bit run, de, eof, apply;
            // registered outputs against last edge's prediction
            chk("out_hs", out_hs, e_hs);
            chk("out_vs", out_vs, e_vs);
            chk("out_de", out_de, e_de);
            chk("out_data", out_data, e_data);
            chk("underflow", underflow, e_uf);
            chk("frame_start", frame_start, e_fs);
            chk("err_cnt", err_cnt, e_err);
            chk("cfg_busy", cfg_busy, e_busy);

            // monitor
            cyc++;
            if (frame_start) begin
                fs_cnt++;
                period_last   = cyc - last_fs_cyc;
                last_fs_cyc   = cyc;
                de_last_frame = de_frame;
                rd_last_frame = rd_frame;
                de_frame = 0;
                rd_frame = 0;
            end
            if (out_de) begin
                de_frame++; de_total++; de_run++;
            end else if (de_run > 0) begin
                run_last = de_run; de_run = 0;
            end
            if (fifo_rd_en) rd_frame++;
            if (underflow) uf_cnt++;

            // model: position -> h/v, window tests in plain integers
            ht  = act_g[3];
            vt  = act_g[7];
            h   = m_pos % ht;
            v   = m_pos / ht;
            run = (m_mode == 2);
            de  = run && (h >= act_g[0] + act_g[1]) && (h < act_g[0] + act_g[1] + act_g[2])
                      && (v >= act_g[4] + act_g[5]) && (v < act_g[4] + act_g[5] + act_g[6]);
            chk("fifo_rd_en", fifo_rd_en, de && !fifo_empty);
            pop_flag = fifo_rd_en;

            e_hs = run && (h < act_g[0]);
            e_vs = run && (v < act_g[4]);
            e_de = de;
            e_uf = de && fifo_empty;
            e_fs = run && (m_pos == 0);
            if (de && !fifo_empty) begin
                e_data = mk_word(m_word);
                m_word++;
            end else if (de) begin
                e_data = FILL_W;
            end else begin
                e_data = '0;
            end

            eof   = run && (m_pos == ht * vt - 1);
            apply = m_busy && !cfg_update && (!run || eof);

            if (apply) m_err = 0;
            else if (e_uf && m_err < 65535) m_err++;

            case (m_mode)
                0: if (enable) m_mode = 1;
                1: if (!enable) m_mode = 0; else if (!fifo_empty) m_mode = 2;
                default: if (eof && !enable) m_mode = 0;
            endcase
            m_pos = (run && !eof) ? m_pos + 1 : 0;

            if (apply) begin
                for (int d = 0; d < 2; d++) begin
                    int s, b, a, t;
                    s = pend_g[4*d]; b = pend_g[4*d+1]; a = pend_g[4*d+2]; t = pend_g[4*d+3];
                    if (t < 2) t = 2;
                    if (s + b >= t) a = 0;
                    else if (a > t - s - b) a = t - s - b;
                    act_g[4*d] = s; act_g[4*d+1] = b; act_g[4*d+2] = a; act_g[4*d+3] = t;
                end
            end
            if (cfg_update) begin
                pend_g = '{int'(cfg_h_sync), int'(cfg_h_back), int'(cfg_h_active), int'(cfg_h_total),
                           int'(cfg_v_sync), int'(cfg_v_back), int'(cfg_v_active), int'(cfg_v_total)};
                m_busy = 1;
            end else if (apply) begin
                m_busy = 0;
            end
            e_err  = m_err;
            e_busy = m_busy;
        end
    end

    // ------------------------------------------------------------ helpers
    task automatic step(input int n);
        repeat (n) begin
            @(posedge rd_clk);
            #1;
        end
    endtask

    task automatic set_cfg(input int hs, input int hb, input int ha, input int ht,
                           input int vs, input int vb, input int va, input int vt);
        step(1);
        cfg_h_sync = CW'(hs); cfg_h_back = CW'(hb); cfg_h_active = CW'(ha); cfg_h_total = CW'(ht);
        cfg_v_sync = CW'(vs); cfg_v_back = CW'(vb); cfg_v_active = CW'(va); cfg_v_total = CW'(vt);
        cfg_update = 1'b1;
        step(1);
        cfg_update = 1'b0;
    endtask

    task automatic wait_fs(input string name);
        int n;
        n = 0;
        while (1) begin
            @(negedge rd_clk);
            if (frame_start) break;
            n++;
            if (n > 2000) begin
                total++;
                bad++;
                $display("FAIL %s: frame_start not seen within 2000 cycles", name);
                break;
            end
        end
        #1;
    endtask

    // ------------------------------------------------------------ sequence
    initial begin : main
        int first_fs, hs_n, uf0, de0, fs0;
        step(3);
        rd_rstn = 1'b1;
        step(2);

        // default 1080p geometry: start latency and HS width
        fifo_empty = 1'b0;
        enable = 1'b1;
        first_fs = -1;
        hs_n = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge rd_clk);
            if (frame_start && first_fs < 0) first_fs = i;
            if (out_hs) hs_n++;
        end
        chk("fs_latency", first_fs, 3);
        chk("default_hs_width", hs_n, 44);

        // asynchronous reset mid-line (VS high on line 0)
        @(posedge rd_clk);
        #3;
        chk("vs_before_rst", out_vs, 1);
        rd_rstn = 1'b0;
        #1;
        chk("async_vs", out_vs, 0);
        chk("async_hs", out_hs, 0);
        chk("async_fs", frame_start, 0);
        enable = 1'b0;
        step(2);
        rd_rstn = 1'b1;
        step(1);

        // small geometry, FIFO never empty
        set_cfg(2, 2, 8, 16, 1, 1, 4, 8);
        step(2);
        enable = 1'b1;
        wait_fs("small_a");
        wait_fs("small_b");
        chk("small_period", period_last, 128);
        chk("small_de", de_last_frame, 32);
        chk("small_rd_en", rd_last_frame, 32);

        // three empty DE beats at h=6..8 of line 2
        uf0 = uf_cnt;
        step(37);
        fifo_empty = 1'b1;
        step(3);
        fifo_empty = 1'b0;
        wait_fs("uf");
        chk("uf_pulses", uf_cnt - uf0, 3);
        chk("uf_err_cnt", err_cnt, 3);
        chk("uf_period", period_last, 128);
        chk("uf_de", de_last_frame, 32);

        // mid-frame h_active 8 -> 4
        step(10);
        set_cfg(2, 2, 4, 16, 1, 1, 4, 8);
        step(5);
        chk("busy_pending", cfg_busy, 1);
        wait_fs("upd_a");
        chk("busy_applied", cfg_busy, 0);
        chk("err_cleared", err_cnt, 0);
        wait_fs("upd_b");
        chk("upd_de", de_last_frame, 16);
        chk("upd_line_de", run_last, 4);

        // clamp: sync+back >= total kills DE
        step(5);
        set_cfg(10, 10, 8, 16, 1, 1, 4, 8);
        wait_fs("clamp_a");
        wait_fs("clamp_b");
        chk("clamp_de", de_last_frame, 0);
        chk("clamp_period", period_last, 128);

        // clamp: h_total 0 -> 2
        step(3);
        set_cfg(1, 0, 8, 0, 1, 1, 4, 8);
        wait_fs("tot_a");
        wait_fs("tot_b");
        chk("tot0_period", period_last, 16);
        chk("tot0_de", de_last_frame, 4);

        // enable dropped mid-frame: frame completes, no new frame
        step(2);
        set_cfg(2, 2, 8, 16, 1, 1, 4, 8);
        wait_fs("drop_a");
        wait_fs("drop_b");
        step(20);
        enable = 1'b0;
        de0 = de_total;
        fs0 = fs_cnt;
        step(250);
        chk("drop_de", de_total - de0, 32);
        chk("drop_fs", fs_cnt - fs0, 0);

        // async reset in the middle of DE
        enable = 1'b1;
        wait_fs("rst_de");
        step(36);
        #2;
        chk("de_before_rst", out_de, 1);
        rd_rstn = 1'b0;
        #1;
        chk("async_de", out_de, 0);
        chk("async_data", out_data, 0);
        chk("async_rd_en", fifo_rd_en, 0);
        step(3);
        rd_rstn = 1'b1;
        // restart under the default geometry restored by reset
        step(60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/disp_tgen_multi.md
# disp_tgen_multi

Parametrised display-timing generator for the disparity output path, running entirely in the `rd_clk` domain. It drains a first-word-fall-through (FWFT) output FIFO and emits HS/VS/DE plus `LANES` pixels per clock. Geometry is programmable at runtime through shadow registers that take effect only on frame boundaries. It handles FIFO underflow with fill pixels and an error counter. Compared with the fixed-LUT, single-pixel predecessor, geometry is per-field programmable and safely clamped, the lane count is generic, and startup/stop are controlled.

## Interface
- `DW`, 8, bits per pixel
- `LANES`, 1, pixels per clock (1, 2 or 4)
- `CW`, 12, width of timing counters and cfg fields
- `FILL`, 0, pixel value emitted on underflow
- `rd_clk` in 1: pixel clock
- `rd_rstn` in 1: reset, asynchronous, active-low; clock `rd_clk`
- `enable` in 1: run request
- `cfg_h_sync`, `cfg_h_back`, `cfg_h_active`, `cfg_h_total` in CW each: horizontal timing, in clocks
- `cfg_v_sync`, `cfg_v_back`, `cfg_v_active`, `cfg_v_total` in CW each: vertical timing, in lines
- `cfg_update` in 1: one-cycle pulse that captures all `cfg_*` into the pending set
- `fifo_empty` in 1: FWFT FIFO empty
- `fifo_data` in DW*LANES: FWFT head word; lane 0 in the LSBs
- `fifo_rd_en` out 1: FIFO pop (combinational)
- `out_data` out DW*LANES: pixel output
- `out_hs`, `out_vs`, `out_de` out 1 each: sync/enable, active-high
- `frame_start` out 1: pulse on the first cycle of each frame
- `underflow` out 1: pulse, DE cycle with FIFO empty
- `err_cnt` out 16: saturating underflow count
- `cfg_busy` out 1: pending set not yet applied

## Operation
- Active set reset values: h 44/148/1920/2200, v 5/36/1080/1125 (sync/back/active/total). Pending set resets to the same values.
- `cfg_update` copies the `cfg_*` inputs into the pending set and sets `cfg_busy`. A second update before apply overwrites the pending set.
- Apply point: in IDLE or WAIT, on the cycle after the update. In RUN, on the cycle with h==h_total-1 and v==v_total-1. Applying clears `cfg_busy` and resets `err_cnt` to 0.
- Clamp at apply:
  - total < 2 becomes 2.
  - If sync+back >= total, active = 0.
  - Otherwise active = min(active, total-sync-back).
  - Sums are computed in CW+1 bits.
- States:
  - IDLE: counters held at 0, all outputs low.
  - IDLE→WAIT when `enable`=1.
  - WAIT→RUN when `fifo_empty`=0; counters start at h=0, v=0.
  - WAIT→IDLE if `enable` drops.
  - RUN→IDLE only at end of frame (h=h_total-1, v=v_total-1) when `enable`=0. A mid-frame drop of `enable` completes the frame.
- Counters (RUN only):
  - h wraps at h_total-1.
  - v increments on h wrap and wraps at v_total-1.
- Decoded signals:
  - hs_c = h < h_sync; vs_c = v < v_sync.
  - de_c = h in [h_sync+h_back, h_sync+h_back+h_active) and v in [v_sync+v_back, v_sync+v_back+v_active).
- `fifo_rd_en` = RUN & de_c & !`fifo_empty`.
- `underflow` pulse = RUN & de_c & `fifo_empty`. `out_data` for that beat = LANES copies of FILL, and `err_cnt` increments, saturating at 0xFFFF.
- Frame counting continues through underflow; the FIFO is never popped when empty.

## Timing
- All outputs except `fifo_rd_en` are registered. Every output resets to 0.
- `out_hs`, `out_vs`, `out_de`, `out_data`, `underflow` and `frame_start` lag the counter state by exactly 1 cycle and are mutually aligned.
- `out_data` is registered from `fifo_data` in the same cycle `fifo_rd_en` is high.
- The first RUN cycle produces `frame_start`=1, `out_hs`=1 and `out_vs`=1 one cycle later.
- An `enable` rise in IDLE with a non-empty FIFO produces the first `frame_start` 3 cycles later: IDLE→WAIT, WAIT→RUN, then the output register.
- Outside DE, `out_data` holds 0.
- A `cfg_update` and an apply point in the same cycle: the new values are captured and applied at the next apply point, not the current one.
- Asynchronous reset mid-frame: all outputs 0 immediately, state IDLE, active set returns to defaults.

## Test plan
- Small geometry h 2/2/8/16, v 1/1/4/8, LANES=1, FIFO always full → each frame gives 32 DE cycles, frame period 128 cycles, and `out_data` equals the FIFO sequence in order.
- LANES=4, incrementing 32-bit words → `out_data` lanes match, and `fifo_rd_en` count equals DE count per frame.
- Hold `fifo_empty`=1 for 3 DE cycles mid-line → 3 `underflow` pulses, FILL on the data, `err_cnt`=3, and frame period unchanged.
- `cfg_update` mid-frame changing h_active 8→4 → `cfg_busy` stays high until the end-of-frame cycle, and the next frame has 4 DE cycles per line.
- cfg h_sync 10, h_back 10, h_total 16 → active clamps to 0 and `out_de` never rises; cfg h_total 0 → period 2.
- `enable` dropped at mid-frame → the frame completes, then IDLE; asserting `rd_rstn` low mid-line zeroes all outputs asynchronously.
